// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the ASCII-decimal counters (counter, counter_up).
//   ASCII_ZERO / ASCII_NINE : byte bounds of a legal ASCII decimal digit
//   state_e                 : FSM state encoding (idle, counting, at limit, rejected load)
//   is_ascii_digit()        : true when a byte lies in '0'..'9'
package counter_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone,
        StError
    } state_e;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/ascii_digit_inc.sv
// ascii_digit_inc: combinational increment of one ASCII decimal digit.
//   digit      : current digit byte ('0'..'9')
//   carry_in   : add one to this digit
//   digit_next : resulting digit byte
//   carry_out  : set when '9' rolled over to '0'
module ascii_digit_inc
    import counter_pkg::*;
(
    input  logic [7:0] digit,
    input  logic       carry_in,
    output logic [7:0] digit_next,
    output logic       carry_out
);

    always_comb begin
        digit_next = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (digit == ASCII_NINE) begin
                digit_next = ASCII_ZERO;
                carry_out  = 1'b1;
            end else begin
                digit_next = digit + 8'd1;
            end
        end
    end

endmodule

// File: rtl/counter_up.sv
// counter_up: ASCII-decimal up-counter with loadable start and limit.
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   load        : sample ascii_start / ascii_limit this edge (beats increment)
//   ascii_start : start value, ASCII digits, MSD in top byte
//   ascii_limit : terminal value, ASCII digits, MSD in top byte
//   increment   : advance one step per cycle while high
//   counter     : current count, ASCII digits (registered)
//   done        : count equals limit (registered level)
//   error       : last load was rejected (registered level)
module counter_up
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS = 2,
    parameter bit          WRAP   = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [8*DIGITS-1:0] ascii_start,
    input  logic [8*DIGITS-1:0] ascii_limit,
    input  logic                increment,
    output logic [8*DIGITS-1:0] counter,
    output logic                done,
    output logic                error
);

    localparam int unsigned W = 8 * DIGITS;
    localparam logic [W-1:0] ALL_ZERO = {DIGITS{ASCII_ZERO}};

    state_e         state_q;
    logic [W-1:0]   count_q;
    logic [W-1:0]   start_q;
    logic [W-1:0]   limit_q;
    logic           done_q;
    logic           error_q;

    logic [W-1:0]   count_inc;
    logic [DIGITS:0] carry;
    logic           digits_ok;
    logic           load_ok;
    logic           inc_hits_limit;

    // Ripple the +1 from the LSD up through the digit chain.
    assign carry[0] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        ascii_digit_inc u_inc (
            .digit      (count_q[8*g +: 8]),
            .carry_in   (carry[g]),
            .digit_next (count_inc[8*g +: 8]),
            .carry_out  (carry[g+1])
        );
    end

    always_comb begin
        digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_ascii_digit(ascii_start[8*i +: 8]) ||
                !is_ascii_digit(ascii_limit[8*i +: 8])) begin
                digits_ok = 1'b0;
            end
        end
    end

    // With every byte in '0'..'9', an unsigned compare of the whole bus is the
    // same as a digit-wise compare starting at the MSD.
    assign load_ok = digits_ok && (ascii_start <= ascii_limit);

    // A rollover past all-'9' is never a legitimate match against the limit.
    assign inc_hits_limit = (count_inc == limit_q) && !carry[DIGITS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= ALL_ZERO;
            start_q <= ALL_ZERO;
            limit_q <= ALL_ZERO;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                start_q <= ascii_start;
                limit_q <= ascii_limit;
                count_q <= ascii_start;
                error_q <= 1'b0;
                if (ascii_start == ascii_limit) begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end else begin
                    done_q  <= 1'b0;
                    state_q <= StCount;
                end
            end else begin
                count_q <= ALL_ZERO;
                error_q <= 1'b1;
                done_q  <= 1'b0;
                state_q <= StError;
            end
        end else if (increment) begin
            case (state_q)
                StCount: begin
                    count_q <= count_inc;
                    if (inc_hits_limit) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (WRAP) begin
                        count_q <= start_q;
                        if (start_q != limit_q) begin
                            done_q  <= 1'b0;
                            state_q <= StCount;
                        end
                    end
                end
                default: begin
                    // Idle and error ignore increment.
                end
            endcase
        end
    end

    assign counter = count_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_counter_up.sv
module tb_counter_up;
    import counter_pkg::*;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned W = 8 * DIGITS;
    localparam logic [W-1:0] NINES = {DIGITS{ASCII_NINE}};

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         load = 1'b0;
    logic         increment = 1'b0;
    logic [W-1:0] ascii_start = '0;
    logic [W-1:0] ascii_limit = '0;

    logic [W-1:0] counter_hold, counter_wrap;
    logic         done_hold, done_wrap, error_hold, error_wrap;

    always #5 clock = ~clock;

    counter_up #(.DIGITS(DIGITS), .WRAP(1'b0)) u_dut_hold (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .ascii_start (ascii_start),
        .ascii_limit (ascii_limit),
        .increment   (increment),
        .counter     (counter_hold),
        .done        (done_hold),
        .error       (error_hold)
    );

    counter_up #(.DIGITS(DIGITS), .WRAP(1'b1)) u_dut_wrap (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .ascii_start (ascii_start),
        .ascii_limit (ascii_limit),
        .increment   (increment),
        .counter     (counter_wrap),
        .done        (done_wrap),
        .error       (error_wrap)
    );

    typedef struct {
        bit           sel;   // 0: hold instance, 1: wrap instance
        logic [W-1:0] cnt;
        logic         done;
        logic         err;
        int           id;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   vec_id = 0;

    task automatic compare(input string name, input logic [W-1:0] ac, input logic ad,
                           input logic ae, input logic [W-1:0] ec, input logic ed,
                           input logic ee);
        n_checks++;
        if (ac !== ec || ad !== ed || ae !== ee) begin
            n_fail++;
            $display("FAIL %s: got counter=\"%s\" done=%b error=%b, expected counter=\"%s\" done=%b error=%b",
                     name, ac, ad, ae, ec, ed, ee);
        end
    endtask

    // Monitor: registered outputs are compared on the falling edge after each
    // stimulus edge, popping the expectation queued by the stimulus process.
    always @(negedge clock) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.sel)
                compare($sformatf("vec%0d_wrap", e.id), counter_wrap, done_wrap, error_wrap,
                        e.cnt, e.done, e.err);
            else
                compare($sformatf("vec%0d_hold", e.id), counter_hold, done_hold, error_hold,
                        e.cnt, e.done, e.err);
        end
    end

    // Assertion: the hold instance must never be asked to count past all-'9'
    // while not at its limit (that would be an overflow).
    always @(posedge clock) begin
        if (reset && !load && increment && counter_hold == NINES && !done_hold) begin
            n_fail++;
            $display("FAIL overflow_guard: counter=\"%s\" done=%b, required done=1",
                     counter_hold, done_hold);
        end
    end

    task automatic step(input bit ld, input logic [W-1:0] s, input logic [W-1:0] l,
                        input bit inc, input bit sel, input logic [W-1:0] ec,
                        input bit ed, input bit ee);
        @(negedge clock);
        load        = ld;
        ascii_start = s;
        ascii_limit = l;
        increment   = inc;
        @(posedge clock);
        sb_q.push_back(exp_t'{sel, ec, ed, ee, vec_id});
        vec_id++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held, then released between edges.
        #12;
        compare("reset_hold", counter_hold, done_hold, error_hold, "00", 1'b0, 1'b0);
        compare("reset_wrap", counter_wrap, done_wrap, error_wrap, "00", 1'b0, 1'b0);
        reset = 1'b1;

        // Idle ignores increment.
        step(0, "00", "00", 0, 0, "00", 0, 0);
        step(0, "00", "00", 1, 0, "00", 0, 0);
        step(0, "00", "00", 1, 0, "00", 0, 0);

        // 07 -> 12, carry from 09 to 10, then hold at limit.
        step(1, "07", "12", 0, 0, "07", 0, 0);
        step(0, "07", "12", 1, 0, "08", 0, 0);
        step(0, "07", "12", 1, 0, "09", 0, 0);
        step(0, "07", "12", 1, 0, "10", 0, 0);
        step(0, "07", "12", 1, 0, "11", 0, 0);
        step(0, "07", "12", 1, 0, "12", 1, 0);
        step(0, "07", "12", 1, 0, "12", 1, 0);
        step(0, "99", "99", 1, 0, "12", 1, 0);  // inputs ignored without load

        // Wrap instance: 18 -> 20, then reload 18.
        step(1, "18", "20", 0, 1, "18", 0, 0);
        step(0, "18", "20", 1, 1, "19", 0, 0);
        step(0, "18", "20", 1, 1, "20", 1, 0);
        step(0, "18", "20", 1, 1, "18", 0, 0);
        step(0, "18", "20", 1, 1, "19", 0, 0);

        // Rejected loads, then recovery.
        step(1, "2A", "30", 0, 0, "00", 0, 1);
        step(0, "2A", "30", 1, 0, "00", 0, 1);
        step(1, "25", "20", 0, 0, "00", 0, 1);
        step(1, "01", "03", 0, 0, "01", 0, 0);
        step(0, "01", "03", 1, 0, "02", 0, 0);

        // Load wins over a simultaneous increment.
        step(1, "00", "09", 0, 0, "00", 0, 0);
        step(0, "00", "09", 1, 0, "01", 0, 0);
        step(0, "00", "09", 1, 0, "02", 0, 0);
        step(0, "00", "09", 1, 0, "03", 0, 0);
        step(0, "00", "09", 1, 0, "04", 0, 0);
        step(0, "00", "09", 1, 0, "05", 0, 0);
        step(1, "00", "09", 1, 0, "00", 0, 0);

        // start == limit: done straight away; wrap instance stays done.
        step(1, "33", "33", 0, 0, "33", 1, 0);
        step(0, "33", "33", 1, 0, "33", 1, 0);
        step(0, "33", "33", 1, 1, "33", 1, 0);

        // Asynchronous reset mid-count at 04.
        step(1, "00", "09", 0, 0, "00", 0, 0);
        step(0, "00", "09", 1, 0, "01", 0, 0);
        step(0, "00", "09", 1, 0, "02", 0, 0);
        step(0, "00", "09", 1, 0, "03", 0, 0);
        step(0, "00", "09", 1, 0, "04", 0, 0);
        @(negedge clock);
        increment = 1'b0;
        #1 reset = 1'b0;
        #1 compare("async_reset", counter_hold, done_hold, error_hold, "00", 1'b0, 1'b0);
        #1 reset = 1'b1;
        // Limit is gone and the counter is idle again.
        step(0, "00", "09", 1, 0, "00", 0, 0);
        step(0, "00", "09", 1, 0, "00", 0, 0);

        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
